addsub_nibble_sequencer: RTL

- Performs multi-word add/subtract (width 4*NIBBLES) through one shared 4-bit ripple-carry adder-subtractor slice.
- Processes one nibble per clock, LSB nibble first, and chains the carry through a register.
- Sits between a requesting controller (start/done handshake) and the nibble datapath.
- The first team block that sequences the add/sub datapath instead of instancing it at full width.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_nibble_sequencer_slice.sv | 24 ++
 rtl/addsub_nibble_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding, slice width and index-width helper.
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the nibble index counter: ceil(log2(n)), never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_nibble_sequencer_slice.sv
// nibble_addsub_slice: combinational 4-bit ripple-carry adder built from
// full adders. Subtract is handled by the sequencer (B inversion, cin=1).
module nibble_addsub_slice
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] c_s;

  assign c_s[0] = cin_i;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum_o[i]  = a_i[i] ^ b_i[i] ^ c_s[i];
    assign c_s[i+1]  = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c_s[NIBBLE_W];

endmodule

// File: rtl/addsub_nibble_sequencer.sv
// addsub_nibble_sequencer: multi-word add/subtract computed one nibble per
// clock (LSB first) through a single shared 4-bit slice, carry chained in a
// register. Optional signed-overflow output enabled by the macro
// ADDSUB_OVERFLOW_FLAG_EN.
module addsub_nibble_sequencer
  import addsub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         sub,
  input  logic [NIBBLES*NIBBLE_W-1:0]  a,
  input  logic [NIBBLES*NIBBLE_W-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLES*NIBBLE_W-1:0]  result,
  output logic                         carry_out
`ifdef ADDSUB_OVERFLOW_FLAG_EN
  ,
  output logic                         ovf
`endif
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic [NIBBLE_W-1:0] a_nib_s, b_nib_s, sum_s;
  logic                cout_s;

  // Select the current nibble of each latched operand; B is inverted for subtract.
  always_comb begin
    a_nib_s = NIBBLE_W'(a_q >> (idx_q * NIBBLE_W));
    b_nib_s = NIBBLE_W'(b_q >> (idx_q * NIBBLE_W)) ^ {NIBBLE_W{sub_q}};
  end

  nibble_addsub_slice u_slice (
    .a_i    (a_nib_s),
    .b_i    (b_nib_s),
    .cin_i  (carry_q),
    .sum_o  (sum_s),
    .cout_o (cout_s)
  );

  // Next-state and datapath update; result/carry_out only move on the completion edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = {IDX_W{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            work_d[n*NIBBLE_W +: NIBBLE_W] = sum_s;
          end else begin
            work_d[n*NIBBLE_W +: NIBBLE_W] = work_q[n*NIBBLE_W +: NIBBLE_W];
          end
        end
        carry_d = cout_s;
        if (idx_q == IDX_LAST) begin
          result_d = work_d;
          cout_d   = cout_s;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
          ovf_d    = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (work_d[W-1] != a_q[W-1]);
`endif
          idx_d    = {IDX_W{1'b0}};
          state_d  = ST_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= {IDX_W{1'b0}};
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      work_q   <= {W{1'b0}};
      result_q <= {W{1'b0}};
      cout_q   <= 1'b0;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule
